// File: rtl/sd_dma_mb.sv
// sd_dma_mb: multi-block SD read DMA from SD data pins to an SRAM write port.
// Define SD_DMA_CRC_EN to check the per-line CRC16 of every block (ERR[1]).
module sd_dma_mb #(
  parameter int CLKDIV = 4,
  parameter int BLK_BYTES = 512,
  parameter int BLK_CNT_W = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [3:0]                 SD_DAT,
  inout  wire                        SD_CLK,
  input  logic                       SD_DMA_EN,
  input  logic                       SD_DMA_WIDE,
  input  logic [BLK_CNT_W-1:0]       SD_DMA_BLKS,
  input  logic                       SD_DMA_PARTIAL,
  input  logic [$clog2(BLK_BYTES):0] SD_DMA_PSTART,
  input  logic [$clog2(BLK_BYTES):0] SD_DMA_PEND,
  output logic                       SD_DMA_STATUS,
  output logic                       SD_DMA_DONE,
  output logic [1:0]                 SD_DMA_ERR,
  output logic                       SD_DMA_SRAM_WE,
  output logic                       SD_DMA_NEXTADDR,
  output logic [7:0]                 SD_DMA_SRAM_DATA
);
  localparam int AW = $clog2(BLK_BYTES) + 1;
  localparam int DW = $clog2(CLKDIV);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, WAIT_START, DATA, CRC, GAP, DONE} state_t;
  state_t state;
  logic [2:0] en_s;
  logic [DW-1:0] div;
  logic wide, partial, to_err, crc_err;
  logic [BLK_CNT_W-1:0] blk_left;
  logic [AW-1:0] pstart, pend, pend_c, bidx;
  logic [2:0] bcnt;
  logic [4:0] ccnt;
  logic [TW-1:0] tcnt;
  logic [7:0] sr, nxt;
  logic en_rise, samp, last_bit, in_win, start_bit;
  assign en_rise = en_s[1] & ~en_s[2];
  assign samp = SD_DMA_STATUS && div == DW'(CLKDIV - 1);
  assign nxt = wide ? {sr[3:0], SD_DAT} : {sr[6:0], SD_DAT[0]};
  assign last_bit = wide ? bcnt[0] : &bcnt;
  assign pend_c = pend > AW'(BLK_BYTES) ? AW'(BLK_BYTES) : pend;
  assign in_win = !partial || (bidx >= pstart && bidx < pend_c);
  assign start_bit = wide ? SD_DAT == 4'h0 : !SD_DAT[0];
  assign SD_CLK = SD_DMA_STATUS ? (div >= DW'(CLKDIV / 2)) : 1'bz;
  assign SD_DMA_ERR = {crc_err, to_err};
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= IDLE;
      en_s <= '0;
      div <= '0;
      wide <= 1'b0;
      partial <= 1'b0;
      blk_left <= '0;
      pstart <= '0;
      pend <= '0;
      bidx <= '0;
      bcnt <= '0;
      ccnt <= '0;
      tcnt <= '0;
      sr <= '0;
      to_err <= 1'b0;
      SD_DMA_STATUS <= 1'b0;
      SD_DMA_DONE <= 1'b0;
      SD_DMA_SRAM_WE <= 1'b1;
      SD_DMA_NEXTADDR <= 1'b0;
      SD_DMA_SRAM_DATA <= '0;
    end else begin
      en_s <= {en_s[1:0], SD_DMA_EN};
      div <= (SD_DMA_STATUS && !samp) ? div + DW'(1) : '0;
      SD_DMA_DONE <= 1'b0;
      SD_DMA_SRAM_WE <= 1'b1;
      SD_DMA_NEXTADDR <= !SD_DMA_SRAM_WE;
      case (state)
        IDLE: if (en_rise) begin
          wide <= SD_DMA_WIDE;
          partial <= SD_DMA_PARTIAL;
          pstart <= SD_DMA_PSTART;
          pend <= SD_DMA_PEND;
          blk_left <= SD_DMA_BLKS;
          to_err <= 1'b0;
          tcnt <= '0;
          if (SD_DMA_BLKS != '0) begin
            state <= WAIT_START;
            SD_DMA_STATUS <= 1'b1;
          end else begin
            state <= DONE;
            SD_DMA_DONE <= 1'b1;
          end
        end
        WAIT_START: if (samp) begin
          if (start_bit) begin
            state <= DATA;
            bidx <= '0;
            bcnt <= '0;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            to_err <= 1'b1;
            state <= DONE;
            SD_DMA_STATUS <= 1'b0;
            SD_DMA_DONE <= 1'b1;
          end else tcnt <= tcnt + TW'(1);
        end
        DATA: if (samp) begin
          sr <= nxt;
          bcnt <= last_bit ? 3'd0 : bcnt + 3'd1;
          if (last_bit) begin
            bidx <= bidx + AW'(1);
            if (in_win) begin
              SD_DMA_SRAM_DATA <= nxt;
              SD_DMA_SRAM_WE <= 1'b0;
            end
            if (bidx == AW'(BLK_BYTES - 1)) begin
              state <= CRC;
              ccnt <= '0;
            end
          end
        end
        // 16 CRC samples followed by the end bit
        CRC: if (samp) begin
          ccnt <= ccnt + 5'd1;
          if (ccnt == 5'd16) state <= GAP;
        end
        GAP: if (samp) begin
          if (blk_left == BLK_CNT_W'(1)) begin
            state <= DONE;
            SD_DMA_STATUS <= 1'b0;
            SD_DMA_DONE <= 1'b1;
          end else begin
            blk_left <= blk_left - BLK_CNT_W'(1);
            tcnt <= '0;
            state <= WAIT_START;
          end
        end
        default: state <= IDLE;
      endcase
    end
`ifdef SD_DMA_CRC_EN
  logic [15:0] crc [4];
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      crc_err <= 1'b0;
      for (int l = 0; l < 4; l++) crc[l] <= '0;
    end else begin
      if (state == IDLE && en_rise) crc_err <= 1'b0;
      for (int l = 0; l < 4; l++)
        if (state == WAIT_START) crc[l] <= '0;
        else if (samp && (wide || l == 0)) begin
          if (state == DATA)
            crc[l] <= {crc[l][14:0], 1'b0} ^ ((crc[l][15] ^ SD_DAT[l]) ? 16'h1021 : 16'h0000);
          else if (state == CRC && ccnt < 5'd16) begin
            crc[l] <= {crc[l][14:0], 1'b0};
            if (crc[l][15] != SD_DAT[l]) crc_err <= 1'b1;
          end
        end
    end
`else
  assign crc_err = 1'b0;
`endif
endmodule

// File: tb/tb_sd_dma_mb.sv
// tb_sd_dma_mb: card model drives SD_DAT on SD_CLK falls and queues expected bytes;
// a monitor pops the queue on every SRAM write strobe.
module tb_sd_dma_mb;
  localparam int CLKDIV = 4;
  localparam int BLK_BYTES = 512;
  localparam int TIMEOUT = 4096;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [3:0] SD_DAT = 4'hF;
  wire SD_CLK;
  pulldown (SD_CLK);
  logic en = 1'b0, wide = 1'b0, partial = 1'b0;
  logic [7:0] blks = '0;
  logic [9:0] pstart = '0, pend = '0;
  logic status, done, we, na;
  logic [1:0] err;
  logic [7:0] data;
  sd_dma_mb dut (
    .CLK(CLK), .RST(RST), .SD_DAT(SD_DAT), .SD_CLK(SD_CLK),
    .SD_DMA_EN(en), .SD_DMA_WIDE(wide), .SD_DMA_BLKS(blks),
    .SD_DMA_PARTIAL(partial), .SD_DMA_PSTART(pstart), .SD_DMA_PEND(pend),
    .SD_DMA_STATUS(status), .SD_DMA_DONE(done), .SD_DMA_ERR(err),
    .SD_DMA_SRAM_WE(we), .SD_DMA_NEXTADDR(na), .SD_DMA_SRAM_DATA(data)
  );
  always #5 CLK = ~CLK;
  int vectors = 0, miscompares = 0;
  int we_cnt = 0, na_cnt = 0, done_cnt = 0, rise_cnt = 0, bad_per = 0, clk_since = 0;
  int c_mode = 0;
  bit c_flip = 0, abort = 0, have_prev = 0;
  logic prev_we = 1'b1, prev_sdclk = 1'b0;
  logic [7:0] exp_q [$];
  event card_go;

  always @(negedge CLK) begin
    logic [7:0] e;
    if (!we) begin
      we_cnt++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sram_data: got unexpected write %02h, expected none", data);
      end else begin
        e = exp_q.pop_front();
        if (data !== e) begin
          miscompares++;
          $display("FAIL sram_data: got %02h, expected %02h", data, e);
        end
      end
    end
    if (na) begin
      na_cnt++;
      vectors++;
      if (prev_we) begin
        miscompares++;
        $display("FAIL nextaddr: got pulse with WE high the cycle before, expected WE low");
      end
    end
    if (done) done_cnt++;
    if (SD_CLK && !prev_sdclk) begin
      rise_cnt++;
      if (have_prev && clk_since != CLKDIV) bad_per++;
      have_prev = 1;
      clk_since = 0;
    end
    clk_since++;
    if (!status) have_prev = 0;
    prev_sdclk = SD_CLK;
    prev_we = we;
  end

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  task automatic sd_drive(input logic [3:0] v);
    @(negedge SD_CLK);
    SD_DAT = v;
  endtask

  task automatic card();
    logic [15:0] crc [4];
    logic [7:0] b;
    logic [3:0] v;
    for (int k = 0; k < 1000 && !status; k++) @(negedge CLK);
    if (!status) return;
    for (int blk = 0; blk < int'(blks); blk++) begin
      repeat (3) sd_drive(4'hF);
      sd_drive(4'h0);
      for (int l = 0; l < 4; l++) crc[l] = '0;
      for (int i = 0; i < BLK_BYTES; i++) begin
        b = c_mode == 1 ? 8'hA5 : 8'(i + blk * 64);
        if (!partial || (i >= int'(pstart) && i < int'(pend) && i < BLK_BYTES)) exp_q.push_back(b);
        if (wide)
          for (int h = 1; h >= 0; h--) begin
            sd_drive(b[h*4+:4]);
            for (int l = 0; l < 4; l++) crc[l] = crc_step(crc[l], b[h*4+l]);
          end
        else
          for (int k = 7; k >= 0; k--) begin
            sd_drive({3'b111, b[k]});
            crc[0] = crc_step(crc[0], b[k]);
          end
        if (abort) return;
      end
      for (int k = 15; k >= 0; k--) begin
        for (int l = 0; l < 4; l++) v[l] = crc[l][k];
        if (c_flip && k == 5) v[2] = ~v[2];
        sd_drive(wide ? v : {3'b111, v[0]});
      end
      sd_drive(4'hF);
    end
  endtask

  initial forever begin
    @(card_go);
    card();
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_en();
    @(negedge CLK);
    en = 1'b1;
    repeat (4) @(negedge CLK);
    en = 1'b0;
  endtask

  task automatic run(input string name, input logic w, input int nb, input int mode, input logic p,
                     input int ps, input int pe, input bit flip, input bit again,
                     input int eerr, input int ewr, input int erise);
    int we0, na0, d0, r0, b0, k;
    wide = w; blks = 8'(nb); partial = p; pstart = 10'(ps); pend = 10'(pe);
    c_mode = mode; c_flip = flip;
    we0 = we_cnt; na0 = na_cnt; d0 = done_cnt; r0 = rise_cnt; b0 = bad_per;
    if (mode >= 0) -> card_go;
    pulse_en();
    if (again) begin
      repeat (300) @(negedge CLK);
      pulse_en();
    end
    k = 0;
    while (done_cnt == d0 && k < 20000 * nb + 100) begin
      @(negedge CLK);
      k++;
    end
    if (done_cnt == d0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s done_wait: got no DONE in %0d cycles, expected DONE", name, k);
    end
    repeat (20) @(negedge CLK);
    check({name, " writes"}, we_cnt - we0, ewr);
    check({name, " nextaddr"}, na_cnt - na0, ewr);
    check({name, " done"}, done_cnt - d0, 1);
    check({name, " err"}, int'(err), eerr);
    check({name, " leftover"}, exp_q.size(), 0);
    check({name, " sdclk_period"}, bad_per - b0, 0);
    check({name, " status"}, int'(status), 0);
    if (erise >= 0) check({name, " sdclk_rises"}, rise_cnt - r0, erise);
  endtask

  initial begin
    int d0;
    repeat (3) @(negedge CLK);
    check("rst status", int'(status), 0);
    check("rst done", int'(done), 0);
    check("rst err", int'(err), 0);
    check("rst we", int'(we), 1);
    check("rst nextaddr", int'(na), 0);
    check("rst data", int'(data), 0);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    run("wide_full", 1, 1, 0, 0, 0, 0, 0, 0, 0, 512, -1);
    run("narrow_a5", 0, 2, 1, 0, 0, 0, 0, 0, 0, 1024, -1);
    run("window_3_5", 1, 2, 0, 1, 3, 5, 0, 1, 0, 4, -1);
    run("timeout", 1, 1, -1, 0, 0, 0, 0, 0, 1, 0, TIMEOUT);
    run("zero_blks", 1, 0, -1, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef SD_DMA_CRC_EN
    run("crc_flip", 1, 1, 0, 0, 0, 0, 1, 0, 2, 512, -1);
`else
    run("crc_flip", 1, 1, 0, 0, 0, 0, 1, 0, 0, 512, -1);
`endif
    run("window_clamp", 1, 1, 0, 1, 508, 1000, 0, 0, 0, 4, -1);
    run("window_empty", 1, 1, 0, 1, 9, 9, 0, 0, 0, 0, -1);
    wide = 1; blks = 1; partial = 0; c_mode = 0; c_flip = 0;
    d0 = done_cnt;
    -> card_go;
    pulse_en();
    repeat (400) @(negedge CLK);
    abort = 1;
    RST = 1'b1;
    @(negedge CLK);
    check("abort status", int'(status), 0);
    check("abort we", int'(we), 1);
    check("abort nextaddr", int'(na), 0);
    check("abort data", int'(data), 0);
    check("abort err", int'(err), 0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    SD_DAT = 4'hF;
    exp_q.delete();
    repeat (10) @(negedge CLK);
    check("abort no_done", done_cnt - d0, 0);
    run("zero_after_rst", 1, 0, -1, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
